// File: rtl/adder_chain_ctrl_if.sv
// Stream and adder-side signal bundle for adder_chain_ctrl.
// The "slave" modport is the sequencer itself. The "master" modport is its
// environment: the upstream byte-pair source, the 8-bit combinational adder
// and the downstream result sink.
interface adder_chain_ctrl_if #(
  parameter int CNT_W = 8
) ();

  // Upstream byte-pair stream
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_cin;

  // Drive to, and return from, the external 8-bit parallel adder
  logic [7:0]       add_a;
  logic [7:0]       add_b;
  logic             add_cin;
  logic [7:0]       add_sum;
  logic             add_cout;

  // Downstream result-byte stream
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_sum;
  logic             out_last;
  logic             out_cout;
  logic             out_ovf;

  // Status
  logic [CNT_W-1:0] word_cnt;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_cin,
    output add_sum, add_cout,
    output out_ready,
    input  in_ready,
    input  add_a, add_b, add_cin,
    input  out_valid, out_sum, out_last, out_cout, out_ovf,
    input  word_cnt, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin,
    input  add_sum, add_cout,
    input  out_ready,
    output in_ready,
    output add_a, add_b, add_cin,
    output out_valid, out_sum, out_last, out_cout, out_ovf,
    output word_cnt, busy
  );

endinterface

// File: rtl/adder_chain_ctrl.sv
// Byte-serial sequencer around an external 8-bit combinational adder.
// Operand words of NBYTES bytes arrive least-significant byte first.
// Each accepted byte pair is added using the carry of the previous byte,
// and the result byte is registered. The final byte of a word carries
// last/carry-out/signed-overflow flags.
module adder_chain_ctrl #(
  parameter int NBYTES = 4,   // bytes per operand word, 2..16
  parameter int CNT_W  = 8    // completed-word counter width
) (
  input  logic              clk,
  input  logic              rst,
  adder_chain_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(NBYTES);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  // FSM encoding
  localparam logic [0:0] IDLE = 1'b0;  // waiting for byte 0 of a word
  localparam logic [0:0] RUN  = 1'b1;  // bytes 1..NBYTES-1 still to come

  // State registers and their next-state values
  logic [0:0]       state_q,     state_d;
  logic [IDX_W-1:0] byte_idx_q,  byte_idx_d;
  logic             carry_q,     carry_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_sum_q,   out_sum_d;
  logic             out_last_q,  out_last_d;
  logic             out_cout_q,  out_cout_d;
  logic             out_ovf_q,   out_ovf_d;
  logic [CNT_W-1:0] word_cnt_q,  word_cnt_d;

  // Handshake and datapath helpers
  logic in_ready;
  logic in_fire;
  logic out_fire;
  logic is_last;
  logic carry_into_msb;

  // The single output register can take a new byte when it is empty or is
  // being drained in this same cycle. There is no skid buffer.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = out_valid_q && bus.out_ready;
  assign is_last  = (byte_idx_q == LAST_IDX);

  // The adder is driven straight from the input byte pair, whether or not
  // in_valid is high. Only accepted cycles update any state.
  assign bus.add_a   = bus.in_a;
  assign bus.add_b   = bus.in_b;
  assign bus.add_cin = (state_q == IDLE) ? bus.in_cin : carry_q;

  // Recover the carry into bit 7 from the sum bit. Signed overflow is that
  // carry XOR the carry out of bit 7.
  assign carry_into_msb = bus.add_sum[7] ^ bus.in_a[7] ^ bus.in_b[7];

  // Next-state logic for the FSM, the carry chain, the output register and
  // the completed-word counter.
  always_comb begin
    // NOTE: every signal gets a hold default before any branch, so no path
    // leaves a value unassigned and no latch can be inferred.
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
    word_cnt_d  = word_cnt_q;

    if (in_fire) begin
      // A new byte overwrites the output register. If the old byte is
      // consumed in this cycle, out_valid simply stays high.
      out_valid_d = 1'b1;
      out_sum_d   = bus.add_sum;
      carry_d     = bus.add_cout;
      out_last_d  = is_last;
      out_cout_d  = is_last && bus.add_cout;
      out_ovf_d   = is_last && (carry_into_msb ^ bus.add_cout);

      if (is_last) begin
        state_d    = IDLE;
        byte_idx_d = '0;
      end else begin
        state_d    = RUN;
        byte_idx_d = byte_idx_q + 1'b1;
      end
    end else if (out_fire) begin
      // The output was drained and nothing replaces it. The payload fields
      // keep their last values.
      out_valid_d = 1'b0;
    end

    // A word counts as completed when its final byte leaves downstream.
    if (out_fire && out_last_q) begin
      word_cnt_d = word_cnt_q + 1'b1;
    end
  end

  // State update with synchronous reset. A reset in mid-word drops the
  // partial word, so no last byte is ever produced for it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge next-state value.
    if (rst) begin
      state_q     <= IDLE;
      byte_idx_q  <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  // Outputs
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.word_cnt  = word_cnt_q;
  assign bus.busy      = (state_q == RUN);

endmodule

// File: doc/adder_chain_ctrl.md
Name: adder_chain_ctrl

Overview:
- Sequencing stage that wraps the 8-bit combinational parallel adder (tt_um_parallel_adder) to add multi-byte operands one byte per cycle.
- Accepts byte pairs on a valid/ready stream and drives the adder's A/B/Cin.
- Registers the adder's Sum/Cout and chains the carry between bytes.
- Emits result bytes on a downstream valid/ready stream, with last/carry/overflow flags on the final byte.

Parameters:
NBYTES, 4, bytes per operand word (2..16), least-significant byte first.
CNT_W, 8, width of completed-word counter.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  byte pair offered
in_ready  out  1  byte pair accepted when in_valid&in_ready
in_a  in  8  operand A byte
in_b  in  8  operand B byte
in_cin  in  1  carry-in for the word; sampled only on byte 0
add_a  out  8  to adder A
add_b  out  8  to adder B
add_cin  out  1  to adder Cin
add_sum  in  8  from adder Sum
add_cout  in  1  from adder Cout
out_valid  out  1  result byte valid
out_ready  in  1  downstream accepts
out_sum  out  8  result byte
out_last  out  1  final byte of word
out_cout  out  1  word carry-out; meaningful only with out_last
out_ovf  out  1  signed overflow of word; meaningful only with out_last
word_cnt  out  CNT_W  completed words emitted, wraps modulo 2^CNT_W
busy  out  1  high while state is RUN

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-high, on ports clk/rst. On reset:
  - state=IDLE, byte_idx=0, carry_q=0, word_cnt=0;
  - out_valid=0; out_sum, out_last, out_cout and out_ovf all 0; busy=0.
- Reset asserted mid-word discards the partial word; no out_last is produced for it.
- FSM:
  - IDLE: waiting for byte 0. On accept with NBYTES>1 go to RUN with byte_idx=1.
  - RUN: on each accept byte_idx+1. When byte NBYTES-1 is accepted, return to IDLE with byte_idx=0.
- Adder drive (combinational):
  - add_a=in_a, add_b=in_b.
  - add_cin = in_cin in IDLE, carry_q in RUN.
  - Drive is valid regardless of in_valid; only accepted cycles update state.
- Handshake: in_ready = !out_valid | out_ready. Single output register, no skid buffer. Full throughput is 1 byte/cycle when out_ready is held high.
- On accept (1-cycle latency, registered next edge):
  - out_sum<=add_sum, out_valid<=1;
  - carry_q<=add_cout;
  - out_last<=(byte_idx==NBYTES-1);
  - out_cout<=add_cout on the last byte, else 0;
  - out_ovf<=(add_sum[7]^in_a[7]^in_b[7])^add_cout on the last byte, else 0. This is the carry into bit 7 XOR the carry out.
- Output hold: out_valid & !out_ready holds out_sum, out_last, out_cout and out_ovf stable; no accept occurs.
- Output drain: out_valid & out_ready & !in_valid → out_valid<=0 next edge.
- Simultaneous out consume and in accept: the register is overwritten with the new byte; out_valid stays 1.
- word_cnt increments on the out handshake of a byte with out_last=1. Wraps 2^CNT_W-1→0.
- in_cin is ignored on bytes 1..NBYTES-1.
- in_valid low mid-word: state and carry_q are held indefinitely.

Test Plan:
1. NBYTES=4, out_ready=1:
   - Stimulus: A=0x00FF_FFFF, B=0x0000_0001, cin=0, bytes LSB first.
   - Required: out_sum 00,00,00,01 on consecutive cycles; out_last on the 4th byte; out_cout=0, out_ovf=0; word_cnt=1.
2. Carry-out/overflow:
   - Stimulus: A=0x7FFF_FFFF, B=0x0000_0001, cin=0.
   - Required: result 0x8000_0000, out_cout=0, out_ovf=1.
   - Stimulus: A=B=0xFFFF_FFFF, cin=1.
   - Required: result 0xFFFF_FFFF, out_cout=1, out_ovf=0.
3. Backpressure:
   - Stimulus: out_ready=0 for 3 cycles after the first result byte.
   - Required: in_ready=0 and out_sum stable for those cycles. Releasing out_ready resumes; the final result is bit-exact versus the golden model.
4. in_cin sampling:
   - Stimulus: cin=1 on byte 0 and cin toggled on later bytes, A=B=0.
   - Required: result 0x0000_0001; later cin values have no effect.
5. Reset mid-word:
   - Stimulus: assert rst after 2 of 4 bytes accepted, then send a full word 0x0000_0002+0x0000_0003.
   - Required: out_valid=0 the cycle after rst, and no out_last from the aborted word. The new word yields 0x0000_0005 and word_cnt=1.
6. Randomised throughput:
   - Stimulus: 300 random words with random in_valid/out_ready gaps.
   - Required: every result matches (A+B+cin) mod 2^32 along with its cout/ovf; word_cnt=300 mod 256=44.
